// File: rtl/frame_buf_master.sv
// Frame-buffer memory initiator: streams pixels into a circular frame region and
// prefetches the same region back through a small output FIFO, one memory port.
module frame_buf_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 29,
  parameter int FRAME_BASE   = 1,
  parameter int FRAME_PIXELS = 307200,
  parameter int BURST_LEN    = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_rdy,
  input  logic                  rd_enable,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_rdy,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic                  wr_rdy,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_data_valid,
  output logic                  wr_frame_done,
  output logic                  rd_frame_done
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(FRAME_BASE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(FRAME_BASE + FRAME_PIXELS - 1);
  localparam logic [CNT_W-1:0]      FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [BEAT_W-1:0]     BURST_MAX  = BEAT_W'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

  state_t                  r_state;
  logic                    r_last_wr;
  logic                    r_rd_outst;
  logic [BEAT_W-1:0]       r_beat;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic                    r_wr_done;
  logic                    r_rd_done;
  logic [DATA_WIDTH-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wptr;
  logic [PTR_W-1:0]        r_rptr;
  logic [CNT_W-1:0]        r_count;

  logic                    w_fifo_full;
  logic                    w_rd_pending;
  logic                    w_wr_beat;
  logic                    w_rd_beat;
  logic                    w_pop;
  logic                    w_rd_leave;
  logic                    w_rd_issue;
  logic [BEAT_W-1:0]       w_beat_inc;
  logic [BEAT_W-1:0]       w_wr_beat_next;

  assign w_fifo_full    = (r_count == FULL_CNT);
  assign w_rd_pending   = rd_enable & ~w_fifo_full;
  assign w_wr_beat      = (r_state == S_WR) & in_valid & wr_rdy;
  assign w_rd_beat      = (r_state == S_RD) & r_rd_outst & rd_data_valid;
  assign w_pop          = out_valid & out_rdy;
  // Beat counter saturates so a late-arriving request on the other side still switches.
  assign w_beat_inc     = (r_beat == BURST_MAX) ? r_beat : r_beat + 1'b1;
  assign w_wr_beat_next = w_wr_beat ? w_beat_inc : r_beat;
  // Leaving RD is decided with nothing in flight, so a new read is never issued on the way out.
  assign w_rd_leave     = (r_state == S_RD) & ~r_rd_outst &
                          (((r_beat == BURST_MAX) & in_valid) | ~rd_enable | w_fifo_full);
  assign w_rd_issue     = (r_state == S_RD) & ~r_rd_outst & ~w_rd_leave;

  assign in_rdy        = (r_state == S_WR) & wr_rdy;
  assign wr_en         = ~((r_state == S_WR) & in_valid);
  assign rd_en         = ~((r_state == S_RD) & (r_rd_outst | w_rd_issue));
  assign wr_addr       = r_wr_addr;
  assign rd_addr       = r_rd_addr;
  assign wr_data       = in_data;
  assign out_valid     = (r_count != '0);
  assign out_data      = out_valid ? r_fifo[r_rptr] : '0;
  assign wr_frame_done = r_wr_done;
  assign rd_frame_done = r_rd_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_last_wr  <= 1'b0;
      r_rd_outst <= 1'b0;
      r_beat     <= '0;
      r_wr_addr  <= FIRST_ADDR;
      r_rd_addr  <= FIRST_ADDR;
      r_wr_done  <= 1'b0;
      r_rd_done  <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_wr_done <= w_wr_beat & (r_wr_addr == LAST_ADDR);
      r_rd_done <= w_rd_beat & (r_rd_addr == LAST_ADDR);
      if (w_wr_beat) r_wr_addr <= (r_wr_addr == LAST_ADDR) ? FIRST_ADDR : r_wr_addr + 1'b1;
      if (w_rd_beat) r_rd_addr <= (r_rd_addr == LAST_ADDR) ? FIRST_ADDR : r_rd_addr + 1'b1;
      if (w_rd_issue)     r_rd_outst <= 1'b1;
      else if (w_rd_beat) r_rd_outst <= 1'b0;
      if (w_rd_beat) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      case ({w_rd_beat, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      case (r_state)
        S_IDLE: begin
          if (w_rd_pending & (r_last_wr | ~in_valid)) begin
            r_state <= S_RD;
            r_beat  <= '0;
          end else if (in_valid) begin
            r_state <= S_WR;
            r_beat  <= '0;
          end
        end
        S_WR: begin
          r_last_wr <= 1'b1;
          if (~in_valid) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
          end else if ((w_wr_beat_next == BURST_MAX) & w_rd_pending) begin
            r_state <= S_RD;
            r_beat  <= '0;
          end else begin
            r_beat <= w_wr_beat_next;
          end
        end
        S_RD: begin
          r_last_wr <= 1'b0;
          if (w_rd_leave) begin
            r_state <= in_valid ? S_WR : S_IDLE;
            r_beat  <= '0;
          end else if (w_rd_beat) begin
            r_beat <= w_beat_inc;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_beat  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_beat) r_fifo[r_wptr] <= rd_data;
  end

endmodule

// File: tb/tb_frame_buf_master.sv
// Bench for frame_buf_master: behavioural memory, frame-order scoreboard and
// burst-alternation tracking, driven by directed phases and random traffic.
module tb_frame_buf_master;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int FB = 1;
  localparam int FP = 8;
  localparam int BL = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_rdy;
  logic          rd_enable = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_rdy = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic          wr_rdy;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          wr_frame_done;
  logic          rd_frame_done;

  frame_buf_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_BASE(FB),
    .FRAME_PIXELS(FP), .BURST_LEN(BL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_rdy(in_rdy),
    .rd_enable(rd_enable),
    .out_data(out_data), .out_valid(out_valid), .out_rdy(out_rdy),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .rd_addr(rd_addr), .rd_en(rd_en),
    .wr_rdy(wr_rdy), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .wr_frame_done(wr_frame_done), .rd_frame_done(rd_frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Memory model and scoreboard state
  logic [DW-1:0] mem    [256];
  logic [DW-1:0] shadow [256];
  int            m_mode = 0;
  logic [AW-1:0] m_last = '0;
  int            m_rd_cnt = 0;
  int            run_kind = 0;
  int            run_len = 0;
  int            run_k[$];
  int            run_l[$];
  logic [DW-1:0] exp_q[$];
  int            wcount = 0;
  int            rcount = 0;
  int            n_pop = 0;
  int            n_wdone = 0;
  int            n_rdone = 0;
  logic          exp_wdone = 1'b0;
  logic          exp_rdone = 1'b0;

  // Memory: write state after one cycle of wr_en low; reads need read state and a new address.
  always @(posedge clk) begin : mem_model
    int ev;
    ev = 0;
    if (reset) begin
      wr_rdy        <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
      m_mode = 0;
      m_last = '0;
    end else begin
      wr_rdy        <= ~wr_en;
      rd_data_valid <= 1'b0;
      if (!wr_en) begin
        if (m_mode == 1 && wr_rdy) begin
          mem[wr_addr] = wr_data;
          ev = 1;
        end
        m_mode = 1;
        m_last = '0;
      end else if (!rd_en) begin
        if (m_mode == 2 && rd_addr != m_last) begin
          rd_data       <= mem[rd_addr];
          rd_data_valid <= 1'b1;
          m_last = rd_addr;
          m_rd_cnt++;
          ev = 2;
        end
        m_mode = 2;
      end else begin
        m_mode = 0;
        m_last = '0;
      end
    end
    if (ev != 0) begin
      if (ev == run_kind) run_len++;
      else begin
        if (run_kind != 0) begin
          run_k.push_back(run_kind);
          run_l.push_back(run_len);
        end
        run_kind = ev;
        run_len  = 1;
      end
    end
  end

  // Frame-order reference: pixel k lands at FB + k mod FP, read k returns that frame word.
  always @(negedge clk) begin : monitor
    int a;
    if (reset) begin
      exp_q.delete();
      wcount = 0;
      rcount = 0;
      exp_wdone = 1'b0;
      exp_rdone = 1'b0;
    end else begin
      check_eq("wr_frame_done", 32'(wr_frame_done), 32'(exp_wdone));
      check_eq("rd_frame_done", 32'(rd_frame_done), 32'(exp_rdone));
      if (wr_frame_done) n_wdone++;
      if (rd_frame_done) n_rdone++;
      exp_wdone = 1'b0;
      exp_rdone = 1'b0;
      check_eq("enables_exclusive", 32'(wr_en | rd_en), 32'd1);
      if (in_valid && in_rdy) begin
        a = FB + wcount % FP;
        check_eq("wr_addr", 32'(wr_addr), 32'(a));
        check_eq("wr_data", wr_data, in_data);
        shadow[a] = in_data;
        exp_wdone = (wcount % FP == FP - 1);
        wcount++;
      end
      if (rd_data_valid) begin
        a = FB + rcount % FP;
        check_eq("rd_addr", 32'(m_last), 32'(a));
        check_eq("rd_data", rd_data, shadow[a]);
        exp_q.push_back(shadow[a]);
        exp_rdone = (rcount % FP == FP - 1);
        rcount++;
      end
      if (out_valid && out_rdy) begin
        if (exp_q.size() == 0) check_eq("pop_expected", 32'(exp_q.size()), 32'd1);
        else check_eq("out_data", out_data, exp_q.pop_front());
        n_pop++;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push_pixels(input int n, input logic [DW-1:0] first, output int cycles);
    int sent;
    sent = 0;
    cycles = 0;
    in_valid = 1'b1;
    in_data = first;
    while (sent < n && cycles < 200) begin
      @(negedge clk);
      if (in_rdy) sent++;
      @(posedge clk);
      #1;
      in_data = first + DW'(sent);
      cycles++;
    end
    in_valid = 1'b0;
    check_eq("push_complete", 32'(sent), 32'(n));
  endtask

  task automatic preload(input logic [DW-1:0] base);
    for (int i = FB; i < FB + FP; i++) begin
      mem[i]    = base + DW'(i);
      shadow[i] = base + DW'(i);
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    rd_enable = 1'b0;
    out_rdy   = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("drain_q_empty", 32'(exp_q.size()), 32'd0);
    check_eq("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin : stim
    int cyc, rd0, wd0, rdn0, p0, guard;
    logic acc, found;

    // Reset values
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_wr_en", 32'(wr_en), 32'd1);
    check_eq("rst_rd_en", 32'(rd_en), 32'd1);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd1);
    check_eq("rst_rd_addr", 32'(rd_addr), 32'd1);
    check_eq("rst_in_rdy", 32'(in_rdy), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_frame_done", 32'({wr_frame_done, rd_frame_done}), 32'd0);
    reset = 1'b0;

    // One full frame of writes
    wd0 = n_wdone;
    push_pixels(FP, 32'hA0, cyc);
    check_eq("frame_write_cycles", 32'(cyc), 32'(FP + 2));
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < FP; i++) check_eq("frame_mem", mem[FB + i], 32'hA0 + 32'(i));
    check_eq("wr_done_count", 32'(n_wdone - wd0), 32'd1);
    check_eq("wr_addr_wrapped", 32'(wr_addr), 32'd1);

    // Prefetch fills the FIFO, stalls, then resumes as it drains
    do_reset();
    preload(32'h1000);
    rd0 = m_rd_cnt;
    rdn0 = n_rdone;
    rd_enable = 1'b1;
    out_rdy = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_eq("stall_read_count", 32'(m_rd_cnt - rd0), 32'd4);
    check_eq("stall_rd_en", 32'(rd_en), 32'd1);
    check_eq("stall_wr_en", 32'(wr_en), 32'd1);
    check_eq("stall_out_valid", 32'(out_valid), 32'd1);
    check_eq("stall_head", out_data, 32'h1001);
    p0 = n_pop;
    out_rdy = 1'b1;
    guard = 0;
    while (n_pop - p0 < FP && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check_eq("readout_pops", 32'(n_pop - p0 >= FP), 32'd1);
    drain();
    check_eq("rd_done_count", 32'(n_rdone - rdn0), 32'd1);

    // Burst alternation with both sides continuously requesting
    do_reset();
    preload(32'h2000);
    run_k.delete();
    run_l.delete();
    run_kind = 0;
    run_len = 0;
    in_data = 32'hB00;
    in_valid = 1'b1;
    rd_enable = 1'b1;
    out_rdy = 1'b1;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      acc = in_rdy;
      @(posedge clk);
      #1;
      if (acc) in_data = in_data + 1;
    end
    drain();
    check_eq("run_count", 32'(run_k.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < run_k.size(); i++) begin
      check_eq("run_kind", 32'(run_k[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
      check_eq("run_len", 32'(run_l[i]), 32'(BL));
    end

    // Write stream with a single-cycle gap, then random mixed traffic
    rd_enable = 1'b0;
    out_rdy = 1'b1;
    wd0 = wcount;
    push_pixels(3, 32'hC0, cyc);
    @(posedge clk);
    #1;
    check_eq("gap_wr_en_high", 32'(wr_en), 32'd1);
    push_pixels(3, 32'hC3, cyc);
    check_eq("gap_write_count", 32'(wcount - wd0), 32'd6);
    for (int c = 0; c < 700; c++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(9) < 8);
      in_data   = $urandom;
      rd_enable = ($urandom_range(9) < 8);
      out_rdy   = ($urandom_range(1) == 1);
    end
    drain();
    repeat (2) @(posedge clk);
    #1;
    for (int i = FB; i < FB + FP; i++) check_eq("final_mem", mem[i], shadow[i]);

    // Reset while a read is in flight
    do_reset();
    rd_enable = 1'b1;
    out_rdy = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(posedge clk);
      #1;
      if (rd_data_valid) found = 1'b1;
    end
    check_eq("inflight_read_seen", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_rd_en", 32'(rd_en), 32'd1);
    check_eq("mid_rst_wr_en", 32'(wr_en), 32'd1);
    check_eq("mid_rst_rd_addr", 32'(rd_addr), 32'd1);
    check_eq("mid_rst_wr_addr", 32'(wr_addr), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("late_resp_dropped", 32'(out_valid), 32'd0);
    p0 = n_pop;
    out_rdy = 1'b1;
    guard = 0;
    while (n_pop - p0 < 3 && guard < 60) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check_eq("post_rst_pops", 32'(n_pop - p0 >= 3), 32'd1);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", n_bad);
    $fatal(1);
  end

endmodule
